// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide responder for the EX stage.
// Optional MADD/MADDU/MSUB/MSUBU (ops 4-7) enabled by defining MDU_MADD_EN.
// Ports: clk, reset (sync, active-high), start/op/a/b request,
//        we_hi/we_lo/wdata direct HI/LO writes, busy, hi, lo outputs.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          commit_q, commit_d;

    logic          op_ok;
    logic          op_div;
    logic          div0;
    logic [31:0]   dvsr;
    logic [31:0]   q_s, r_s, q_u, r_u;
    logic [63:0]   prod_s, prod_u;
    logic [63:0]   res;

    always_comb begin
`ifdef MDU_MADD_EN
        op_ok = (op[3] == 1'b0);
`else
        op_ok = (op[3:2] == 2'b00);
`endif
        op_div = op_ok && (op[2:1] == 2'b01);
        div0   = (b == 32'd0);
        // Divider never sees zero; a zero divisor suppresses the commit.
        dvsr   = div0 ? 32'd1 : b;
    end

    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};
        q_u    = a / dvsr;
        r_u    = a % dvsr;
        // Most-negative / -1 overflows; architectural result is fixed.
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
        end else begin
            q_s = $signed(a) / $signed(dvsr);
            r_s = $signed(a) % $signed(dvsr);
        end
    end

    always_comb begin
        res = '0;
        case (op[2:0])
            3'd0: res = prod_s;
            3'd1: res = prod_u;
            3'd2: res = {r_s, q_s};
            3'd3: res = {r_u, q_u};
`ifdef MDU_MADD_EN
            3'd4: res = {hi_q, lo_q} + prod_s;
            3'd5: res = {hi_q, lo_q} + prod_u;
            3'd6: res = {hi_q, lo_q} - prod_s;
            3'd7: res = {hi_q, lo_q} - prod_u;
`endif
            default: res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            commit_q  <= commit_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        commit_d  = commit_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_ok) begin
                        state_d   = RUN;
                        cnt_d     = op_div ? CW'(DIV_CYCLES)
                                           : CW'(MULT_CYCLES);
                        pend_hi_d = res[63:32];
                        pend_lo_d = res[31:0];
                        commit_d  = !(op_div && div0);
                    end
                end else begin
                    if (we_hi) hi_d = wdata;
                    if (we_lo) lo_d = wdata;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (commit_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == RUN);
        hi   = hi_q;
        lo   = lo_q;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide responder for the pipelined MIPS core, instantiated in the EX stage beside the ALU.
- The pipeline acts as initiator: it issues start/op with operands, or writes HI/LO directly (mthi/mtlo).
- The unit answers with a multi-cycle busy window, then commits the results to HI/LO.
- The pipeline stalls HI/LO-dependent instructions while start or busy is high.

Parameters:
- MULT_CYCLES, 5: busy cycles for a multiply-class op (must be ≥1).
- DIV_CYCLES, 10: busy cycles for a divide-class op (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request pulse; sampled with op/a/b.
- op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, others reserved.
- a  input  32  operand rs.
- b  input  32  operand rt.
- we_hi  input  1  mthi write strobe.
- we_lo  input  1  mtlo write strobe.
- wdata  input  32  mthi/mtlo data.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (synchronous, on the clock edge with reset=1): hi=0, lo=0, busy=0, counter=0, state=IDLE.
  - Reset mid-operation aborts the operation. Pending results are discarded and no commit occurs.
- States: IDLE, RUN.
- IDLE, start=1, valid op (edge N):
  - Latch operands; compute the result into internal pend_hi/pend_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from after edge N.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter reaches 0: hi/lo take pend_hi/pend_lo, busy=0, state=IDLE.
  - busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles.
  - hi/lo hold their old values throughout the busy window.
- start during RUN: ignored, no queueing.
- Reserved op (8-15) with start: ignored, busy stays 0.
- we_hi/we_lo in IDLE with start=0: the corresponding register takes wdata at the edge. Both may be asserted together.
- we_hi/we_lo during RUN: ignored.
- start and we_* asserted in the same IDLE cycle: start wins; the write is dropped.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient into lo, unsigned remainder into hi.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b=0, DIV or DIVU): the busy window still runs; hi/lo are left unchanged at commit.
- MADD family (ops 4-7), when enabled:
  - MADD/MADDU: {hi,lo} = {hi,lo} + product, computed from the hi/lo value at the start edge, modulo 2^64.
  - MSUB/MSUBU: {hi,lo} = {hi,lo} − product, computed the same way, modulo 2^64.
  - Latency is MULT_CYCLES.
- hi/lo are direct register outputs with no combinational path from the inputs.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 4-7 are implemented as described above.
- Not defined:
  - Ops 4-7 are treated as reserved: start is ignored, busy stays 0, hi/lo are unchanged.
  - No accumulate adder is synthesised.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (−3), b=5:
  - busy=1 for exactly 5 cycles.
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1 on the cycle busy falls; earlier hi/lo=0.
- MULTU a=0xFFFFFFFF, b=2 → after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2:
  - busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU of the same operands → lo=0x7FFFFFFC, hi=0x00000001.
- Divide by zero and illegal writes:
  - mthi 0x1234, mtlo 0x5678, then DIV b=0 → busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
  - we_lo=1 during busy is ignored.
  - A second start during busy is ignored (busy falls after the first 10 cycles only).
- Reset during operation:
  - Start MULTU 7×9 and assert reset on busy cycle 3 → next cycle busy=0, hi=lo=0.
  - No later commit of 63.
- With MDU_MADD_EN:
  - hi=0, lo=0xFFFFFFFF, then MADDU 1×1 → hi=1, lo=0.
  - Then MSUB 2×3 → hi=0, lo=0xFFFFFFFA.
- Without MDU_MADD_EN: op=4 start → busy stays 0, hi/lo unchanged.
